// File: rtl/johnson_phase_sequencer_if.sv
// johnson_phase_sequencer_if: control and status bundle for the Johnson phase sequencer
interface johnson_phase_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
);
  logic             start;
  logic [CNTW-1:0]  steps;
  logic             dir;
  logic             pause;
  logic             stop;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic [2*WIDTH-1:0] phase;
  logic             busy;
  logic             done;
  logic             err;
  modport master (
    output start, steps, dir, pause, stop, load, load_val,
    input  Q, phase, busy, done, err
  );
  modport slave (
    input  start, steps, dir, pause, stop, load, load_val,
    output Q, phase, busy, done, err
  );
endinterface

// File: rtl/johnson_phase_sequencer.sv
// johnson_phase_sequencer: run/stop controller around a Johnson counter with one-hot phase decode
module johnson_phase_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input logic clk,
  input logic reset,
  johnson_phase_sequencer_if.slave bus
);
  localparam int IW = $clog2(2*WIDTH+1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, q_step;
  logic [CNTW-1:0]  rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IW-1:0]    idx;
  function automatic int popcount(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction
  // A legal Johnson code has at most one 0/1 boundary when scanned end to end.
  function automatic logic legal(input logic [WIDTH-1:0] v);
    int t;
    t = 0;
    for (int i = 0; i < WIDTH-1; i++) t += int'(v[i] ^ v[i+1]);
    return t <= 1;
  endfunction
  // State and datapath registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  // Next state: load beats start in IDLE; stop beats pause beats advance while running.
  always_comb begin
    q_step  = dir_q ? {~q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          q_d   = legal(bus.load_val) ? bus.load_val : '0;
          err_d = !legal(bus.load_val);
        end else if (bus.start) begin
          dir_d   = bus.dir;
          err_d   = 1'b0;
          done_d  = bus.steps == '0;
          rem_d   = bus.steps;
          state_d = bus.steps == '0 ? IDLE : RUN;
        end
      end
      RUN: begin
        if (bus.stop) state_d = IDLE;
        else if (bus.pause) state_d = PAUSE;
        else begin
          q_d     = q_step;
          rem_d   = rem_q - CNTW'(1);
          done_d  = rem_q == CNTW'(1);
          state_d = rem_q == CNTW'(1) ? IDLE : RUN;
        end
      end
      PAUSE: state_d = bus.stop ? IDLE : bus.pause ? PAUSE : RUN;
      default: state_d = IDLE;
    endcase
  end
  // Outputs: busy follows the next state; phase is a one-hot decode of the ring position.
  always_comb begin
    busy_d    = state_d != IDLE;
    idx       = q_q[WIDTH-1] ? IW'(2*WIDTH - popcount(q_q)) : IW'(popcount(q_q));
    bus.phase = (2*WIDTH)'(1) << idx;
  end
  assign bus.Q    = q_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_johnson_phase_sequencer.sv
// tb_johnson_phase_sequencer: directed vector table plus hand-written multi-cycle sequences
module tb_johnson_phase_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  johnson_phase_sequencer_if #(.WIDTH(4), .CNTW(8)) bus ();
  johnson_phase_sequencer #(.WIDTH(4), .CNTW(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       st;
    logic [7:0] steps;
    logic       dir;
    logic       pa;
    logic       sp;
    logic [3:0] eq;
    logic       eb;
    logic       ed;
    logic       ee;
  } vec_t;
  vec_t vecs[$];
  function automatic logic [7:0] ph(input logic [3:0] q);
    case (q)
      4'b0000: return 8'h01;
      4'b0001: return 8'h02;
      4'b0011: return 8'h04;
      4'b0111: return 8'h08;
      4'b1111: return 8'h10;
      4'b1110: return 8'h20;
      4'b1100: return 8'h40;
      4'b1000: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic a(input logic ld, input logic [3:0] lv, input logic st, input logic [7:0] steps,
                   input logic dir, input logic pa, input logic sp,
                   input logic [3:0] eq, input logic eb, input logic ed, input logic ee);
    vec_t v;
    v = '{ld, lv, st, steps, dir, pa, sp, eq, eb, ed, ee};
    vecs.push_back(v);
  endtask
  task automatic drive(input logic ld, input logic [3:0] lv, input logic st, input logic [7:0] steps,
                       input logic dir, input logic pa, input logic sp);
    bus.load = ld; bus.load_val = lv; bus.start = st; bus.steps = steps;
    bus.dir = dir; bus.pause = pa; bus.stop = sp;
  endtask
  task automatic chk_all(input string tag, input logic [3:0] eq, input logic eb, input logic ed, input logic ee);
    chk({tag, ".Q"}, 32'(bus.Q), 32'(eq));
    chk({tag, ".phase"}, 32'(bus.phase), 32'(ph(eq)));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(eb));
    chk({tag, ".done"}, 32'(bus.done), 32'(ed));
    chk({tag, ".err"}, 32'(bus.err), 32'(ee));
  endtask
  initial begin
    int nb;
    bit got_done;
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk_all("reset_async", 4'b0000, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_all("reset_state", 4'b0000, 0, 0, 0);
    // forward run of 8
    a(0,0,1,8,0,0,0, 4'b0000,1,0,0);
    a(0,0,0,0,0,0,0, 4'b0001,1,0,0);
    a(0,0,0,0,0,0,0, 4'b0011,1,0,0);
    a(0,0,0,0,0,0,0, 4'b0111,1,0,0);
    a(0,0,0,0,0,0,0, 4'b1111,1,0,0);
    a(0,0,0,0,0,0,0, 4'b1110,1,0,0);
    a(0,0,0,0,0,0,0, 4'b1100,1,0,0);
    a(0,0,0,0,0,0,0, 4'b1000,1,0,0);
    a(0,0,0,0,0,0,0, 4'b0000,0,1,0);
    a(0,0,0,0,0,0,0, 4'b0000,0,0,0);
    // reverse run of 3
    a(1,4'b0000,0,0,0,0,0, 4'b0000,0,0,0);
    a(0,0,1,3,1,0,0, 4'b0000,1,0,0);
    a(0,0,0,0,0,0,0, 4'b1000,1,0,0);
    a(0,0,0,0,0,0,0, 4'b1100,1,0,0);
    a(0,0,0,0,0,0,0, 4'b1110,0,1,0);
    a(0,0,0,0,0,0,0, 4'b1110,0,0,0);
    // pause mid-run, then stop
    a(1,4'b0000,0,0,0,0,0, 4'b0000,0,0,0);
    a(0,0,1,10,0,0,0, 4'b0000,1,0,0);
    a(0,0,0,0,0,0,0, 4'b0001,1,0,0);
    a(0,0,0,0,0,0,0, 4'b0011,1,0,0);
    a(0,0,0,0,0,1,0, 4'b0011,1,0,0);
    a(0,0,0,0,0,1,0, 4'b0011,1,0,0);
    a(0,0,0,0,0,1,0, 4'b0011,1,0,0);
    a(0,0,0,0,0,0,0, 4'b0011,1,0,0);
    a(0,0,0,0,0,0,0, 4'b0111,1,0,0);
    a(0,0,0,0,0,0,1, 4'b0111,0,0,0);
    a(0,0,0,0,0,0,0, 4'b0111,0,0,0);
    // stop (with pause) after 2nd advance
    a(1,4'b0000,0,0,0,0,0, 4'b0000,0,0,0);
    a(0,0,1,5,0,0,0, 4'b0000,1,0,0);
    a(0,0,0,0,0,0,0, 4'b0001,1,0,0);
    a(0,0,0,0,0,0,0, 4'b0011,1,0,0);
    a(0,0,0,0,0,1,1, 4'b0011,0,0,0);
    a(0,0,0,0,0,0,0, 4'b0011,0,0,0);
    // preload legality and sticky err
    a(1,4'b0110,0,0,0,0,0, 4'b0000,0,0,1);
    a(0,0,0,0,0,0,0, 4'b0000,0,0,1);
    a(1,4'b1100,0,0,0,0,0, 4'b1100,0,0,0);
    a(1,4'b1010,0,0,0,0,0, 4'b0000,0,0,1);
    a(1,4'b1110,0,0,0,0,0, 4'b1110,0,0,0);
    a(0,0,1,0,0,0,0, 4'b1110,0,1,0);
    a(0,0,0,0,0,0,0, 4'b1110,0,0,0);
    a(1,4'b0110,0,0,0,0,0, 4'b0000,0,0,1);
    a(0,0,1,0,0,0,0, 4'b0000,0,1,0);
    // load wins over start
    a(1,4'b0111,1,4,0,0,0, 4'b0111,0,0,0);
    a(0,0,0,0,0,0,0, 4'b0111,0,0,0);
    // start/load ignored while busy
    a(0,0,1,2,0,0,0, 4'b0111,1,0,0);
    a(1,4'b0000,1,9,1,0,0, 4'b1111,1,0,0);
    a(0,0,1,9,1,0,0, 4'b1110,0,1,0);
    a(0,0,0,0,0,0,0, 4'b1110,0,0,0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].steps, vecs[i].dir, vecs[i].pa, vecs[i].sp);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eb, vecs[i].ed, vecs[i].ee);
    end
    // wrap-around: 10 forward steps from 0000 end at 0011
    drive(1, 4'b0000, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 1, 10, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    nb = bus.busy ? 1 : 0;
    got_done = 1'b0;
    for (int k = 0; k < 40 && !got_done; k++) begin
      @(posedge clk); #1;
      if (bus.done) got_done = 1'b1;
      else if (bus.busy) nb++;
    end
    chk("wrap.done_seen", 32'(got_done), 32'd1);
    chk("wrap.busy_cycles", 32'(nb), 32'd10);
    chk_all("wrap.end", 4'b0011, 0, 1, 0);
    // asynchronous reset between edges mid-run
    drive(1, 4'b0000, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 1, 20, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_all("pre_reset", 4'b0111, 1, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk_all("mid_reset", 4'b0000, 0, 0, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk_all("post_reset", 4'b0000, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/johnson_phase_sequencer.md
Name: johnson_phase_sequencer

Overview:
Run/stop controller wrapped around a parameterizable twisted-ring (Johnson) counter. It advances the counter forward or in reverse for a programmed number of steps, supports pause, abort and parallel preload, and decodes the ring into one-hot phase enables for multiphase timing in the lab designs. On preload it checks that the value is a legal Johnson code and recovers from illegal values.

Parameters:
WIDTH, 4, ring width in flops; the sequence length is 2*WIDTH states.
CNTW, 8, width of the step-count field.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a run of `steps` advances; sampled only in IDLE
steps  input  CNTW  number of advances for the run; captured when start is accepted
dir  input  1  0 = forward, 1 = reverse; captured when start is accepted
pause  input  1  hold the counter while high (RUN only)
stop  input  1  abort the run immediately
load  input  1  preload request; accepted only in IDLE
load_val  input  WIDTH  preload value
Q  output  WIDTH  Johnson counter state
phase  output  2*WIDTH  one-hot decode of Q
busy  output  1  high in RUN or PAUSE
done  output  1  one-cycle pulse when a run completes normally
err  output  1  sticky illegal-preload flag

Behaviour:
- Interface: one clock (clk). reset is asynchronous and active-high.
- Reset values: Q=0, phase=1 (bit0), busy=0, done=0, err=0, FSM=IDLE, remaining=0. Asserting reset mid-run aborts the run immediately with no done pulse.
- Forward step: Q <= {Q[WIDTH-2:0], ~Q[WIDTH-1]}.
  - For WIDTH=4 the sequence is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
- Reverse step: Q <= {~Q[0], Q[WIDTH-1:1]}, which is the exact inverse of the forward step.
- Phase decode is combinational:
  - idx = popcount(Q) if Q[WIDTH-1]=0, else 2*WIDTH - popcount(Q).
  - phase = 1<<idx.
  - Legal Q values map to the indices 0..2*WIDTH-1.
- Legal code: Q is legal iff it has the form 0..01..1 or 1..10..0, i.e. at most one 0/1 transition when bits are scanned MSB to LSB. All-0 and all-1 are legal.
- FSM states: IDLE, RUN, PAUSE.
- IDLE:
  - If load=1: evaluate load_val.
    - Legal: Q <= load_val and err <= 0.
    - Illegal: Q <= 0 and err <= 1.
    - load has priority over start in the same cycle; start is ignored that cycle.
  - Else if start=1:
    - Capture steps and dir; clear err.
    - If steps=0: pulse done on the next cycle, stay in IDLE, Q unchanged.
    - Otherwise set remaining <= steps and go to RUN.
    - The first advance occurs on the clock edge after start is accepted.
- RUN: per-cycle priority is stop > pause > advance.
  - stop=1: go to IDLE, Q holds, no done pulse.
  - pause=1: go to PAUSE, Q holds.
  - Otherwise: advance Q in the captured direction and decrement remaining.
    - When remaining=1 at an advance, go to IDLE and assert done for exactly the following cycle.
- PAUSE:
  - stop=1: go to IDLE with no done pulse.
  - pause=0: return to RUN; advancing resumes on the next edge.
  - Otherwise hold Q and remaining.
- Not sampled while busy: start, load, steps and dir are all ignored in RUN and PAUSE.
- Wrap-around: runs longer than 2*WIDTH steps wrap around the sequence modulo 2*WIDTH.
- Busy/done relation: busy is high throughout RUN and PAUSE; done is never asserted while busy=1.
- Register boundaries: Q, busy, done and err are registered; phase is a combinational decode of the registered Q.

Test Plan:
- Reset, then start, steps=8, dir=0 (WIDTH=4):
  - Q must walk 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 on consecutive cycles.
  - phase must read 0x02 up to 0x80, then 0x01.
  - busy must be high for exactly 8 cycles; done must pulse once, one cycle after the last advance.
- Preload Q=0000, start, steps=3, dir=1: Q must step 1000, 1100, 1110; done must pulse; final phase=0x20.
- Pause and stop mid-run:
  - Start, steps=10, forward. Hold pause for 3 cycles after the 2nd advance: Q must stay 0011 and busy must stay 1. Release pause: Q must resume at 0111.
  - Start, steps=5, forward; assert stop after the 2nd advance: FSM must return to IDLE, Q must hold 0011, done must stay 0.
- Preload checks:
  - load_val=0110 (illegal): Q must become 0000 and err must go to 1.
  - Then load_val=1100 (legal): Q must become 1100, err must go to 0, phase must read 0x40.
- Simultaneous and zero-length requests:
  - load=1 and start=1 in the same IDLE cycle: load must be applied and busy must stay 0.
  - start with steps=0: done must pulse and Q must be unchanged.
  - start asserted while busy: must be ignored.
- Asynchronous reset asserted between clock edges mid-run: Q=0, busy=0, done=0 and err=0 must take effect immediately, without waiting for a clock edge.
